rcc_lsi_ctrl: RTL and testbench
===============================

Name: rcc_lsi_ctrl

Overview:
- LSI oscillator enable/ready sequencer, directly upstream of the VDD-domain RCC register block.
- Combines the software LSION bit with the independent-watchdog force requests and drives the analog LSI enable.
- Times oscillator start-up and shutdown and produces `lsi_rdy`, which the register block captures as the LSIRDY status bit.
- Optional clock-security monitor flags a stalled LSI.

Parameters:
- STARTUP_CYC, 64, clk cycles from `lsi_en` rising to `lsi_rdy` rising; legal range 2..255.
- STOP_CYC, 4, clk cycles `lsi_en` stays low before a restart is permitted; legal range 1..255.
- CNT_W, 8, down-counter width; must hold max(STARTUP_CYC, STOP_CYC).
- CSS_TIMEOUT, 16, clk cycles without an LSI toggle before failure is declared (optional feature only); legal range 2..255.

Ports:
- clk  in  1  VDD-domain clock
- rst_n  in  1  synchronous active-low reset
- lsion  in  1  software LSI enable, i.e. the current LSION register bit
- iwdg1_lsi_req  in  1  IWDG1 running; forces LSI on
- iwdg2_lsi_req  in  1  IWDG2 running; forces LSI on
- lsi_en  out  1  analog LSI oscillator enable
- lsi_rdy  out  1  LSI stable; feeds the register block's `lsi_rdy`
- lsi_busy  out  1  high in STARTING or STOPPING
- lsi_clk_tgl  in  1  LSI divided-clock toggle, already synchronised to clk (present only with RCC_LSI_CSS_EN)
- lsi_css_fail  out  1  sticky LSI failure flag (present only with RCC_LSI_CSS_EN)

Behaviour:
- Interface: one clock, `clk`. Reset `rst_n` is synchronous and active-low. All state changes occur on the rising edge of `clk`.
- Reset values: state = OFF; cnt = 0; `lsi_en` = 0, `lsi_rdy` = 0, `lsi_busy` = 0, `lsi_css_fail` = 0.
- Reset asserted mid-operation in any state returns to OFF on the next edge. No stop wait is applied.
- req = lsion | iwdg1_lsi_req | iwdg2_lsi_req, sampled each edge.
- All outputs are registered decodes of state; no combinational input-to-output path.
- States:
  - OFF: `lsi_en` = 0, `lsi_rdy` = 0. If req = 1, go to STARTING and load cnt = STARTUP_CYC-1.
  - STARTING: `lsi_en` = 1, `lsi_rdy` = 0.
    - If req = 0: go to STOPPING, load cnt = STOP_CYC-1.
    - Else if cnt = 0: go to READY.
    - Else: cnt decrements by 1.
  - READY: `lsi_en` = 1, `lsi_rdy` = 1. If req = 0, go to STOPPING and load cnt = STOP_CYC-1.
  - STOPPING: `lsi_en` = 0, `lsi_rdy` = 0.
    - When cnt = 0: go to STARTING (load STARTUP_CYC-1) if req = 1, else go to OFF.
    - Otherwise cnt decrements. req changes are ignored until the count expires.
- Latency:
  - req rises in OFF at edge N: `lsi_en` = 1 after edge N.
  - `lsi_rdy` = 1 after edge N+STARTUP_CYC.
  - req falls in READY at edge M: `lsi_en` and `lsi_rdy` = 0 after edge M.
  - Earliest re-enable is after edge M+STOP_CYC.
- Req pulse of one cycle in OFF still runs STARTING for exactly one cycle, then a full STOPPING period.
- Counter never wraps. Decrements occur only when cnt ≠ 0.

Optional Feature:
- Macro: RCC_LSI_CSS_EN.
- When defined:
  - In READY, a watchdog counter reloads to CSS_TIMEOUT-1 on every cycle where `lsi_clk_tgl` differs from its registered previous value, and decrements otherwise.
  - Reaching 0 with no toggle sets `lsi_css_fail` = 1 and moves the FSM to STOPPING.
  - `lsi_css_fail` is sticky: cleared only by reset, or on the edge where req goes 0→1 from OFF.
  - The counter is reloaded on entry to READY.
  - While `lsi_css_fail` = 1, STOPPING exits to OFF regardless of req.
- When undefined: `lsi_clk_tgl` and `lsi_css_fail` ports and their logic do not exist.

Test Plan:
- Reset, then lsion = 1 at edge 10 (STARTUP_CYC = 64) -> `lsi_en` = 1 after edge 10; `lsi_busy` = 1 through edge 73; `lsi_rdy` = 1 after edge 74.
- READY, lsion = 0 at edge 100 with iwdg1_lsi_req = 1 held -> `lsi_en` and `lsi_rdy` stay 1 (OR of requests).
- READY, all req = 0 at edge 200, lsion = 1 again at edge 201 (STOP_CYC = 4) -> `lsi_en` = 0 for edges 200..203; STARTING after edge 204; `lsi_rdy` = 1 after edge 268.
- lsion pulsed for 1 cycle from OFF -> `lsi_en` high for 1 cycle, low for 4 cycles, then OFF; `lsi_rdy` never asserts.
- `rst_n` = 0 at STARTING cnt = 30 -> all outputs 0 next edge; after release with req = 1, full 64-cycle start-up repeats.
- RCC_LSI_CSS_EN, READY, `lsi_clk_tgl` frozen for 16 cycles -> `lsi_css_fail` = 1, `lsi_rdy` = 0, STOPPING then OFF with lsion still 1; lsion 0→1 clears the flag and restarts.

Source files
------------

// File: rtl/rcc_lsi_ctrl.sv
// LSI oscillator enable/ready sequencer.
// Merges the software LSION bit with the IWDG force requests, drives the
// analog LSI enable, times start-up and shutdown and reports lsi_rdy.
// Optional clock-security monitor: define RCC_LSI_CSS_EN to build it.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// OFF      | oscillator disabled, waiting for a request
// STARTING | oscillator enabled, start-up timer running
// READY    | oscillator enabled and stable
// STOPPING | oscillator disabled, minimum off-time before a restart
module rcc_lsi_ctrl #(
   parameter int STARTUP_CYC = 64,
   parameter int STOP_CYC    = 4,
   parameter int CNT_W       = 8,
   parameter int CSS_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic lsion,
   input  logic iwdg1_lsi_req,
   input  logic iwdg2_lsi_req,
`ifdef RCC_LSI_CSS_EN
   input  logic lsi_clk_tgl,
   output logic lsi_css_fail,
`endif
   output logic lsi_en,
   output logic lsi_rdy,
   output logic lsi_busy
);

   typedef enum logic [1:0] {
      OFF      = 2'd0,
      STARTING = 2'd1,
      READY    = 2'd2,
      STOPPING = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] START_LD = CNT_W'(STARTUP_CYC - 1);
   localparam logic [CNT_W-1:0] STOP_LD  = CNT_W'(STOP_CYC - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             req;
   logic             start_ok;
   logic             fail_q;

   assign req = lsion | iwdg1_lsi_req | iwdg2_lsi_req;

`ifdef RCC_LSI_CSS_EN
   localparam int WD_W = 8;
   localparam logic [WD_W-1:0] WD_LD = WD_W'(CSS_TIMEOUT - 1);

   logic [WD_W-1:0] wd, wd_nxt;
   logic            fail_nxt;
   logic            tgl_q;
   logic            req_q;

   // After a clock failure only a fresh 0->1 request may restart the LSI.
   assign start_ok     = req & (~fail_q | ~req_q);
   assign lsi_css_fail = fail_q;
`else
   assign start_ok = req;
   assign fail_q   = 1'b0;
`endif

   // Next-state and timer logic.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
`ifdef RCC_LSI_CSS_EN
      wd_nxt    = wd;
      fail_nxt  = fail_q;
`endif
      case (state)
         OFF: begin
            if (start_ok) begin
               state_nxt = STARTING;
               cnt_nxt   = START_LD;
`ifdef RCC_LSI_CSS_EN
               fail_nxt  = 1'b0;
`endif
            end
         end
         STARTING: begin
            if (!req) begin
               state_nxt = STOPPING;
               cnt_nxt   = STOP_LD;
            end else if (cnt == '0) begin
               state_nxt = READY;
`ifdef RCC_LSI_CSS_EN
               wd_nxt    = WD_LD;
`endif
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         READY: begin
            if (!req) begin
               state_nxt = STOPPING;
               cnt_nxt   = STOP_LD;
            end
`ifdef RCC_LSI_CSS_EN
            else if (lsi_clk_tgl != tgl_q) begin
               wd_nxt = WD_LD;
            end else if (wd == '0) begin
               fail_nxt  = 1'b1;
               state_nxt = STOPPING;
               cnt_nxt   = STOP_LD;
            end else begin
               wd_nxt = wd - 1'b1;
            end
`endif
         end
         STOPPING: begin
            if (cnt == '0) begin
               if (req && !fail_q) begin
                  state_nxt = STARTING;
                  cnt_nxt   = START_LD;
               end else begin
                  state_nxt = OFF;
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = OFF;
      endcase
   end

   // State, timers and registered output decodes of the next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= OFF;
         cnt      <= '0;
         lsi_en   <= 1'b0;
         lsi_rdy  <= 1'b0;
         lsi_busy <= 1'b0;
`ifdef RCC_LSI_CSS_EN
         wd       <= '0;
         fail_q   <= 1'b0;
         tgl_q    <= 1'b0;
         req_q    <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         lsi_en   <= (state_nxt == STARTING) || (state_nxt == READY);
         lsi_rdy  <= (state_nxt == READY);
         lsi_busy <= (state_nxt == STARTING) || (state_nxt == STOPPING);
`ifdef RCC_LSI_CSS_EN
         wd       <= wd_nxt;
         fail_q   <= fail_nxt;
         tgl_q    <= lsi_clk_tgl;
         req_q    <= req;
`endif
      end
   end

endmodule

// File: tb/tb_rcc_lsi_ctrl.sv
// Scoreboard bench for rcc_lsi_ctrl (STARTUP_CYC = 64, STOP_CYC = 4).
// Edge k is the k-th rising clock edge; an expectation for edge k is
// compared on the falling edge that follows it.
module tb_rcc_lsi_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic lsion = 1'b0;
   logic iwdg1_lsi_req = 1'b0;
   logic iwdg2_lsi_req = 1'b0;
   logic lsi_en, lsi_rdy, lsi_busy;
   logic lsi_clk_tgl = 1'b0;
   logic tgl_run = 1'b1;
   logic lsi_css_fail_obs;

   int edge_cnt = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int    edge_no;
      logic  en;
      logic  rdy;
      logic  busy;
      logic  fail;
      string name;
   } exp_t;

   exp_t sb[$];

   rcc_lsi_ctrl #(
      .STARTUP_CYC(64),
      .STOP_CYC(4),
      .CNT_W(8),
      .CSS_TIMEOUT(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .lsion(lsion),
      .iwdg1_lsi_req(iwdg1_lsi_req),
      .iwdg2_lsi_req(iwdg2_lsi_req),
`ifdef RCC_LSI_CSS_EN
      .lsi_clk_tgl(lsi_clk_tgl),
      .lsi_css_fail(lsi_css_fail_obs),
`endif
      .lsi_en(lsi_en),
      .lsi_rdy(lsi_rdy),
      .lsi_busy(lsi_busy)
   );

`ifndef RCC_LSI_CSS_EN
   assign lsi_css_fail_obs = 1'b0;
`endif

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Synchronised LSI divided-clock toggle, changes once per clk cycle.
   always @(posedge clk) begin
      #2;
      if (tgl_run) lsi_clk_tgl = ~lsi_clk_tgl;
   end

   task automatic expect_at(input int k, input logic en, input logic rdy,
                            input logic busy, input logic fail, input string name);
      exp_t e;
      e.edge_no = k;
      e.en = en;
      e.rdy = rdy;
      e.busy = busy;
      e.fail = fail;
      e.name = name;
      sb.push_back(e);
   endtask

   // Returns on the falling edge just before edge k.
   task automatic at_edge(input int k);
      do @(negedge clk); while (edge_cnt < k - 1);
   endtask

   // Monitor: pops and compares every expectation due at this edge.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (e.edge_no < edge_cnt) begin
            errors++;
            $display("FAIL %s: expectation for edge %0d not checked in time (now %0d)",
                     e.name, e.edge_no, edge_cnt);
         end else if (lsi_en !== e.en || lsi_rdy !== e.rdy || lsi_busy !== e.busy
                      || lsi_css_fail_obs !== e.fail) begin
            errors++;
            $display("FAIL %s @edge %0d: en/rdy/busy/fail got %b%b%b%b expected %b%b%b%b",
                     e.name, edge_cnt, lsi_en, lsi_rdy, lsi_busy, lsi_css_fail_obs,
                     e.en, e.rdy, e.busy, e.fail);
         end
      end
   end

   initial begin
      expect_at(2, 0, 0, 0, 0, "reset");
      expect_at(3, 0, 0, 0, 0, "reset_hold");
      at_edge(4);
      rst_n = 1'b1;
      expect_at(5, 0, 0, 0, 0, "idle_off");
      expect_at(9, 0, 0, 0, 0, "idle_off_late");
      at_edge(10);
      lsion = 1'b1;
      expect_at(10, 1, 0, 1, 0, "start_en");
      expect_at(40, 1, 0, 1, 0, "start_mid");
      expect_at(73, 1, 0, 1, 0, "start_last");
      expect_at(74, 1, 1, 0, 0, "ready");

      at_edge(90);
      iwdg1_lsi_req = 1'b1;
      at_edge(100);
      lsion = 1'b0;
      expect_at(100, 1, 1, 0, 0, "iwdg1_hold");
      expect_at(101, 1, 1, 0, 0, "iwdg1_hold2");
      expect_at(150, 1, 1, 0, 0, "iwdg1_hold3");
      expect_at(199, 1, 1, 0, 0, "ready_pre_stop");
      at_edge(200);
      iwdg1_lsi_req = 1'b0;
      expect_at(200, 0, 0, 1, 0, "stop_en_low");
      at_edge(201);
      lsion = 1'b1;
      expect_at(203, 0, 0, 1, 0, "stop_ignores_req");
      expect_at(204, 1, 0, 1, 0, "restart");
      expect_at(267, 1, 0, 1, 0, "restart_last");
      expect_at(268, 1, 1, 0, 0, "restart_ready");

      at_edge(300);
      lsion = 1'b0;
      expect_at(303, 0, 0, 1, 0, "stop_last");
      expect_at(304, 0, 0, 0, 0, "stop_to_off");

      at_edge(320);
      lsion = 1'b1;
      expect_at(320, 1, 0, 1, 0, "pulse_en");
      at_edge(321);
      lsion = 1'b0;
      expect_at(321, 0, 0, 1, 0, "pulse_stop");
      expect_at(324, 0, 0, 1, 0, "pulse_stop_last");
      expect_at(325, 0, 0, 0, 0, "pulse_off");
      expect_at(330, 0, 0, 0, 0, "pulse_no_rdy");

      at_edge(400);
      lsion = 1'b1;
      expect_at(400, 1, 0, 1, 0, "pre_rst_start");
      expect_at(433, 1, 0, 1, 0, "pre_rst_cnt30");
      at_edge(434);
      rst_n = 1'b0;
      expect_at(434, 0, 0, 0, 0, "mid_reset");
      expect_at(435, 0, 0, 0, 0, "mid_reset_hold");
      at_edge(436);
      rst_n = 1'b1;
      expect_at(436, 1, 0, 1, 0, "post_rst_start");
      expect_at(499, 1, 0, 1, 0, "post_rst_last");
      expect_at(500, 1, 1, 0, 0, "post_rst_ready");

      at_edge(505);
      iwdg2_lsi_req = 1'b1;
      at_edge(510);
      lsion = 1'b0;
      expect_at(510, 1, 1, 0, 0, "iwdg2_hold");
      expect_at(550, 1, 1, 0, 0, "iwdg2_hold2");
      at_edge(560);
      iwdg2_lsi_req = 1'b0;
      expect_at(560, 0, 0, 1, 0, "iwdg2_drop");
      expect_at(563, 0, 0, 1, 0, "iwdg2_stop_last");
      expect_at(564, 0, 0, 0, 0, "iwdg2_off");

`ifdef RCC_LSI_CSS_EN
      at_edge(700);
      lsion = 1'b1;
      expect_at(764, 1, 1, 0, 0, "css_ready");
      at_edge(780);
      tgl_run = 1'b0;
      expect_at(795, 1, 1, 0, 0, "css_last_ok");
      expect_at(796, 0, 0, 1, 1, "css_fail");
      expect_at(799, 0, 0, 1, 1, "css_stop_last");
      expect_at(800, 0, 0, 0, 1, "css_off");
      expect_at(805, 0, 0, 0, 1, "css_stay_off");
      at_edge(810);
      lsion = 1'b0;
      at_edge(812);
      lsion = 1'b1;
      expect_at(812, 1, 0, 1, 0, "css_clear_restart");
`endif

      at_edge(900);
      @(negedge clk);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
